// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: state encodings, state width
// and a small helper used to size the shared cycle counter.
package pll_reset_sequencer_pkg;

    localparam int STATE_W    = 3;
    localparam int LOSS_CNT_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Synchronizer for the asynchronous PLL LOCKED pin into the board clock domain.
// Chain depth is SYNC_STAGES; all stages clear to 0 on reset_n.
module pll_lock_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pll_locked,
    output logic locked_s
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift the raw pin in at the bottom of the chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pll_locked};
    end

    // Synchronizer flops, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses PLL RST, waits for and qualifies LOCKED, then
// releases the system reset; restarts on loss of lock and gives up after a
// bounded number of lock timeouts.
// Optional feature macro: PLL_SEQ_LOSS_CNT_EN adds the saturating lock_loss_cnt
// output counting RUN->PLL_RST restarts caused by loss of lock.
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int RETRY_MAX        = 7,
    parameter int SYNC_STAGES      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pll_locked,
    input  logic                  soft_rst,
    output logic                  pll_rst,
    output logic                  sys_rst_n,
    output logic                  ready,
    output logic                  fail,
    output logic [STATE_W-1:0]    state_o
`ifdef PLL_SEQ_LOSS_CNT_EN
    ,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
`endif
);

    localparam int CNT_W   = $clog2(max3(RST_PULSE_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC)) + 1;
    localparam int RETRY_W = $clog2(RETRY_MAX) + 1;

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(RETRY_MAX);

    logic               locked_s;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [RETRY_W-1:0] retry_inc;
    logic               pll_rst_q, pll_rst_d;
    logic               sys_rst_n_q, sys_rst_n_d;
    logic               ready_q, ready_d;
    logic               fail_q, fail_d;
`ifdef PLL_SEQ_LOSS_CNT_EN
    logic                  loss_ev;
    logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
`endif

    pll_lock_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .locked_s   (locked_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_PLL_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the shared cycle counter and retry bookkeeping.
    // The counter restarts from 0 on every state entry; soft_rst overrides all.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        retry_inc = retry_q + 1'b1;
`ifdef PLL_SEQ_LOSS_CNT_EN
        loss_ev   = 1'b0;
`endif
        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_PLL_RST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
`ifdef PLL_SEQ_LOSS_CNT_EN
                    loss_ev = 1'b1;
`endif
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_PLL_RST;
                cnt_d   = '0;
            end
        endcase
        if (soft_rst) begin
            state_d = ST_PLL_RST;
            cnt_d   = '0;
            retry_d = '0;
`ifdef PLL_SEQ_LOSS_CNT_EN
            loss_ev = 1'b0;
`endif
        end
    end

    // Output decode from the next state so outputs move on the same edge as the state.
    always_comb begin
        pll_rst_d   = (state_d == ST_PLL_RST);
        sys_rst_n_d = (state_d == ST_RUN);
        ready_d     = (state_d == ST_RUN);
        fail_d      = (state_d == ST_FAIL);
    end

    // Counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
        end
    end

`ifdef PLL_SEQ_LOSS_CNT_EN
    // Saturating lock-loss count; survives soft_rst, cleared only by reset_n.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (loss_ev && (loss_cnt_q != {LOSS_CNT_W{1'b1}})) begin
            loss_cnt_d = loss_cnt_q + 1'b1;
        end
    end

    // Lock-loss counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign lock_loss_cnt = loss_cnt_q;
`endif

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters.
module tb_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       soft_rst = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fail;
    logic [2:0] state_o;
`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    int vec_cnt = 0;
    int miscompare_cnt = 0;
    int hi_cnt;
    int pulse_cnt;
    logic prev_rst;

    pll_reset_sequencer #(
        .RST_PULSE_CYC    (4),
        .LOCK_STABLE_CYC  (8),
        .LOCK_TIMEOUT_CYC (32),
        .RETRY_MAX        (3),
        .SYNC_STAGES      (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .soft_rst   (soft_rst),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .fail       (fail),
        .state_o    (state_o)
`ifdef PLL_SEQ_LOSS_CNT_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompare_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(2);
        check_vec("rst_pll_rst", pll_rst, 1);
        check_vec("rst_sys_rst_n", sys_rst_n, 0);
        check_vec("rst_ready", ready, 0);
        check_vec("rst_fail", fail, 0);
        check_vec("rst_state", state_o, 0);

        // Scenario 1: bring-up, lock at cycle 10
        reset_n = 1'b1;
        #1;
        check_vec("s1_c0_pll_rst", pll_rst, 1);
        tick(3);
        check_vec("s1_c3_pll_rst", pll_rst, 1);
        tick(1);
        check_vec("s1_c4_pll_rst", pll_rst, 0);
        check_vec("s1_c4_state", state_o, 1);
        tick(6);
        pll_locked = 1'b1;
        tick(2);
        check_vec("s1_c12_state", state_o, 1);
        tick(1);
        check_vec("s1_c13_state", state_o, 2);
        tick(7);
        check_vec("s1_c20_sys_rst_n", sys_rst_n, 0);
        check_vec("s1_c20_state", state_o, 2);
        tick(1);
        check_vec("s1_c21_sys_rst_n", sys_rst_n, 1);
        check_vec("s1_c21_ready", ready, 1);
        check_vec("s1_c21_state", state_o, 3);

        // Scenario 4: lock loss in RUN
        pll_locked = 1'b0;
        tick(1);
        check_vec("s4_sync_hold_ready", ready, 1);
        tick(2);
        check_vec("s4_sys_rst_n", sys_rst_n, 0);
        check_vec("s4_pll_rst", pll_rst, 1);
        check_vec("s4_ready", ready, 0);
        check_vec("s4_state", state_o, 0);
        pll_locked = 1'b1;
        tick(4);
        check_vec("s4_wait_state", state_o, 1);
        tick(1);
        check_vec("s4_stable_state", state_o, 2);

        // Scenario 3: 1-cycle dropout at stable count 5
        tick(5);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(2);
        check_vec("s3_back_wait", state_o, 1);
        check_vec("s3_no_pulse", pll_rst, 0);
        tick(1);
        check_vec("s3_restable", state_o, 2);
        tick(7);
        check_vec("s3_c7_state", state_o, 2);
        check_vec("s3_c7_sys_rst_n", sys_rst_n, 0);
        tick(1);
        check_vec("s3_run_state", state_o, 3);
        check_vec("s3_run_ready", ready, 1);
`ifdef PLL_SEQ_LOSS_CNT_EN
        check_vec("s4_loss_cnt", lock_loss_cnt, 1);
`endif

        // Scenario 6: soft_rst in RUN, held for 3 edges
        soft_rst = 1'b1;
        tick(1);
        check_vec("s6_state", state_o, 0);
        check_vec("s6_pll_rst", pll_rst, 1);
        check_vec("s6_sys_rst_n", sys_rst_n, 0);
        tick(2);
        check_vec("s6_held_state", state_o, 0);
        soft_rst = 1'b0;
        tick(3);
        check_vec("s6_pulse_c3", state_o, 0);
        tick(1);
        check_vec("s6_wait", state_o, 1);
        tick(1);
        check_vec("s6_stable", state_o, 2);
        tick(8);
        check_vec("s6_run", state_o, 3);
`ifdef PLL_SEQ_LOSS_CNT_EN
        check_vec("s6_loss_cnt", lock_loss_cnt, 1);
`endif

        // Scenario 2: no lock, retries exhaust into FAIL
        pll_locked = 1'b0;
        soft_rst = 1'b1;
        tick(1);
        soft_rst = 1'b0;
        hi_cnt = pll_rst ? 1 : 0;
        pulse_cnt = pll_rst ? 1 : 0;
        prev_rst = pll_rst;
        for (int k = 1; k < 108; k++) begin
            tick(1);
            if (pll_rst) hi_cnt++;
            if (pll_rst && !prev_rst) pulse_cnt++;
            prev_rst = pll_rst;
        end
        check_vec("s2_rst_hi_cycles", hi_cnt, 12);
        check_vec("s2_rst_pulses", pulse_cnt, 3);
        check_vec("s2_pre_fail_state", state_o, 1);
        tick(1);
        check_vec("s2_fail_state", state_o, 4);
        check_vec("s2_fail", fail, 1);
        check_vec("s2_fail_pll_rst", pll_rst, 0);
        check_vec("s2_fail_sys_rst_n", sys_rst_n, 0);
        tick(50);
        check_vec("s2_fail_sticky_state", state_o, 4);
        check_vec("s2_fail_sticky", fail, 1);
        soft_rst = 1'b1;
        tick(1);
        soft_rst = 1'b0;
        check_vec("s2_soft_state", state_o, 0);
        check_vec("s2_soft_pll_rst", pll_rst, 1);
        check_vec("s2_soft_fail", fail, 0);

        // Scenario 5: async reset mid-WAIT_LOCK
        tick(4);
        check_vec("s5_wait_state", state_o, 1);
        check_vec("s5_wait_pll_rst", pll_rst, 0);
        tick(2);
        #2;
        reset_n = 1'b0;
        #1;
        check_vec("s5_async_pll_rst", pll_rst, 1);
        check_vec("s5_async_state", state_o, 0);
        check_vec("s5_async_sys_rst_n", sys_rst_n, 0);
        check_vec("s5_async_fail", fail, 0);
        tick(1);
        reset_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
        $finish;
    end

endmodule
